// File: rtl/bht_counter_writer_pkg.sv
// Shared definitions for the branch-history counter table write side:
// FSM encodings, counter limits and the update pipeline register layout.
package bht_counter_writer_pkg;

    localparam int ENTRIES = 32;
    localparam int INDEX_W = 5;

    localparam logic [1:0] SAT_MAX = 2'b11;
    localparam logic [1:0] SAT_MIN = 2'b00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    // Update held between the accept edge and the write edge.
    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic               taken;
        logic [1:0]         cur;
    } s1_t;

endpackage

// File: rtl/sat_counter_2bit_next.sv
// Next value of a 2-bit saturating counter: step toward 2'b11 when taken,
// toward 2'b00 when not taken, holding at either end.
module sat_counter_2bit_next
    import bht_counter_writer_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nxt
);

    always_comb begin
        // NOTE: default assigned first so every path drives nxt and no latch is inferred.
        nxt = cur;
        if (taken) begin
            if (cur != SAT_MAX) nxt = cur + 2'd1;
        end else begin
            if (cur != SAT_MIN) nxt = cur - 2'd1;
        end
    end

endmodule

// File: rtl/bht_counter_writer.sv
// Write side of the 32-entry 2-bit branch-history table: pipelined saturating
// updates with same-index forwarding, plus a one-entry-per-cycle clear walk.
module bht_counter_writer
    import bht_counter_writer_pkg::*;
#(
    parameter logic [1:0] INIT_STATE = 2'b01,
    parameter int          ENTRIES    = bht_counter_writer_pkg::ENTRIES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   upd_valid,
    output logic                   upd_ready,
    input  logic [INDEX_W-1:0]     upd_index,
    input  logic                   upd_taken,
    input  logic                   clr_req,
    output logic                   clr_busy,
    output logic [2*ENTRIES-1:0]   table_out,
    output logic                   wr_done
);

    state_t             state, state_nxt;
    s1_t                s1_q;
    logic [1:0]         cnt [ENTRIES];
    logic [INDEX_W-1:0] clr_ptr;
    logic               out_of_reset;

    logic               accept;
    logic               s2_valid;
    logic [1:0]         s2_next;
    logic [1:0]         rd_val;
    logic [1:0]         fwd_val;

    logic               wr_en;
    logic [INDEX_W-1:0] wr_index;
    logic [1:0]         wr_value;
    logic [ENTRIES-1:0] wr_sel;

    // The pipeline register holds a pending write exactly when the FSM is in UPDATE.
    assign s2_valid = (state == UPDATE);

    sat_counter_2bit_next u_sat (
        .cur   (s1_q.cur),
        .taken (s1_q.taken),
        .nxt   (s2_next)
    );

    // Forward the in-flight result so back-to-back updates to one entry chain correctly.
    assign rd_val  = cnt[upd_index];
    assign fwd_val = (s2_valid && (s1_q.index == upd_index)) ? s2_next : rd_val;

    always_comb begin
        state_nxt = state;
        upd_ready = 1'b0;
        clr_busy  = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE, UPDATE: begin
                upd_ready = out_of_reset && !clr_req;
                accept    = upd_valid && upd_ready;
                if (clr_req)     state_nxt = CLEAR;
                else if (accept) state_nxt = UPDATE;
                else             state_nxt = IDLE;
            end
            CLEAR: begin
                clr_busy = 1'b1;
                if (clr_ptr == INDEX_W'(ENTRIES - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A pending S2 write retires on the edge that enters CLEAR; clear writes follow.
    always_comb begin
        wr_en    = 1'b0;
        wr_index = s1_q.index;
        wr_value = s2_next;
        if (state == CLEAR) begin
            wr_en    = 1'b1;
            wr_index = clr_ptr;
            wr_value = INIT_STATE;
        end else if (s2_valid) begin
            wr_en = 1'b1;
        end
    end

    always_comb begin
        wr_sel = '0;
        for (int k = 0; k < ENTRIES; k++) begin
            wr_sel[k] = wr_en && (wr_index == INDEX_W'(k));
        end
    end

    // NOTE: non-blocking assignments for all sequential state so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            s1_q         <= '0;
            clr_ptr      <= '0;
            wr_done      <= 1'b0;
            out_of_reset <= 1'b0;
        end else begin
            state        <= state_nxt;
            wr_done      <= s2_valid;
            out_of_reset <= 1'b1;
            if (accept) begin
                s1_q.index <= upd_index;
                s1_q.taken <= upd_taken;
                s1_q.cur   <= fwd_val;
            end
            if (state == CLEAR) clr_ptr <= clr_ptr + INDEX_W'(1);
        end
    end

    // NOTE: the table is reset like any other state since reset must leave every entry at INIT_STATE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < ENTRIES; k++) cnt[k] <= INIT_STATE;
        end else begin
            for (int k = 0; k < ENTRIES; k++) begin
                if (wr_sel[k]) cnt[k] <= wr_value;
            end
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_flat
        assign table_out[2*g +: 2] = cnt[g];
    end

endmodule

// File: tb/tb_bht_counter_writer.sv
// Directed bench for bht_counter_writer: saturating updates, forwarding,
// clear walk timing and asynchronous reset abort.
module tb_bht_counter_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic        upd_valid;
    logic        upd_ready;
    logic [4:0]  upd_index;
    logic        upd_taken;
    logic        clr_req;
    logic        clr_busy;
    logic [63:0] table_out;
    logic        wr_done;

    localparam logic [63:0] ALL_INIT = 64'h5555_5555_5555_5555;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] exp_tab;

    always #5 clock = ~clock;

    bht_counter_writer dut (
        .clock     (clock),
        .reset     (reset),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_index (upd_index),
        .upd_taken (upd_taken),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .table_out (table_out),
        .wr_done   (wr_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_e(input int k, input logic [1:0] v);
        exp_tab[2*k +: 2] = v;
    endtask

    function automatic logic [1:0] ent(input int k);
        return table_out[2*k +: 2];
    endfunction

    initial begin
        int n;
        int bad_ready;

        reset     = 1'b0;
        upd_valid = 1'b0;
        upd_index = '0;
        upd_taken = 1'b0;
        clr_req   = 1'b0;
        exp_tab   = ALL_INIT;

        // Reset state and release.
        #12;
        check("rst_table", table_out, ALL_INIT);
        check("rst_ready", upd_ready, 1'b0);
        check("rst_busy", clr_busy, 1'b0);
        check("rst_wr_done", wr_done, 1'b0);
        #10 reset = 1'b1;
        #1 check("ready_before_edge", upd_ready, 1'b0);
        tick();
        check("ready_after_edge", upd_ready, 1'b1);

        // Entry 7 taken x3 back-to-back: 01 -> 10 -> 11 -> 11.
        upd_valid = 1'b1; upd_index = 5'd7; upd_taken = 1'b1;
        tick();
        check("e7_accept1", ent(7), 2'b01);
        check("wr_done_idle", wr_done, 1'b0);
        tick();
        check("e7_write1", ent(7), 2'b10);
        check("wr_done1", wr_done, 1'b1);
        tick();
        upd_valid = 1'b0;
        check("e7_write2", ent(7), 2'b11);
        check("wr_done2", wr_done, 1'b1);
        tick();
        check("e7_write3_sat", ent(7), 2'b11);
        check("wr_done3", wr_done, 1'b1);
        set_e(7, 2'b11);
        check("table_after_e7", table_out, exp_tab);
        tick();
        check("wr_done_end", wr_done, 1'b0);

        // Entry 0 not-taken x2: 01 -> 00 -> 00.
        upd_valid = 1'b1; upd_index = 5'd0; upd_taken = 1'b0;
        tick();
        tick();
        upd_valid = 1'b0;
        check("e0_write1", ent(0), 2'b00);
        tick();
        check("e0_write2_sat", ent(0), 2'b00);
        set_e(0, 2'b00);
        check("table_after_e0", table_out, exp_tab);

        // Alternate entries 3 and 4, taken, every cycle.
        upd_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            upd_valid = 1'b1;
            upd_index = (i % 2 == 0) ? 5'd3 : 5'd4;
            tick();
        end
        upd_valid = 1'b0;
        tick();
        tick();
        set_e(3, 2'b11);
        set_e(4, 2'b11);
        check("table_after_3_4", table_out, exp_tab);

        // Clear with an update pending in S2 and upd_valid held high.
        upd_valid = 1'b1; upd_index = 5'd10; upd_taken = 1'b1;
        tick();
        clr_req = 1'b1;
        #1 check("ready_blocked_by_clr", upd_ready, 1'b0);
        tick();
        clr_req = 1'b0;
        check("clr_pending_write", ent(10), 2'b10);
        check("clr_pending_wr_done", wr_done, 1'b1);
        check("clr_busy_start", clr_busy, 1'b1);
        n = 0;
        bad_ready = 0;
        while (clr_busy && n < 40) begin
            if (upd_ready) bad_ready++;
            clr_req = (n == 5);
            n++;
            tick();
        end
        clr_req = 1'b0;
        check("clr_busy_cycles", n, 32);
        check("clr_ready_low", bad_ready, 0);
        check("clr_ready_after", upd_ready, 1'b1);
        check("clr_table", table_out, ALL_INIT);
        tick();
        tick();
        upd_valid = 1'b0;
        check("post_clr_update", ent(10), 2'b10);
        check("post_clr_wr_done", wr_done, 1'b1);

        // Reset mid-clear at clr_ptr = 12.
        upd_valid = 1'b1; upd_index = 5'd20; upd_taken = 1'b1;
        tick();
        tick();
        upd_valid = 1'b0;
        tick();
        check("e20_before_clr", ent(20), 2'b11);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (12) tick();
        check("midclr_busy", clr_busy, 1'b1);
        check("midclr_e10_cleared", ent(10), 2'b01);
        check("midclr_e20_pending", ent(20), 2'b11);
        #2 reset = 1'b0;
        #1;
        check("rst_midclr_table", table_out, ALL_INIT);
        check("rst_midclr_busy", clr_busy, 1'b0);
        check("rst_midclr_ready", upd_ready, 1'b0);
        #20 reset = 1'b1;
        tick();
        check("midclr_recover_busy", clr_busy, 1'b0);
        check("midclr_recover_ready", upd_ready, 1'b1);

        // Reset mid-update with wr_done high and another update in S1.
        upd_valid = 1'b1; upd_index = 5'd5; upd_taken = 1'b1;
        tick();
        tick();
        check("midupd_e5", ent(5), 2'b10);
        check("midupd_wr_done", wr_done, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rst_midupd_table", table_out, ALL_INIT);
        check("rst_midupd_wr_done", wr_done, 1'b0);
        check("rst_midupd_ready", upd_ready, 1'b0);
        upd_valid = 1'b0;
        #20 reset = 1'b1;
        tick();
        tick();
        check("midupd_aborted_table", table_out, ALL_INIT);
        check("midupd_aborted_wr_done", wr_done, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
